mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between instruction fetch (IF) and data access (MEM).
- Generates the sticky IF_DONE / MEM_DONE pair that advances the IF/ID and later pipeline registers. A pipeline step is defined as the cycle with IF_DONE && MEM_DONE.
- Serves one transaction at a time. MEM has priority over IF within a stage because it belongs to the older instruction.
- Sits between the CPU core and the memory/bus wrapper.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch needed this stage
if_addr  in  ADDR_W  fetch address (PC)
IF_DONE  out  1  fetch of current stage complete (or not needed); sticky until step
IF_inst  out  DATA_W  fetched instruction; valid while IF_DONE=1
mem_req  in  1  load/store needed this stage
mem_we  in  1  1=store, 0=load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_wstrb  in  DATA_W/8  store byte enables
MEM_DONE  out  1  data access of current stage complete (or not needed); sticky until step
mem_rdata  out  DATA_W  load data; valid while MEM_DONE=1
m_valid  out  1  memory request valid
m_ready  in  1  memory accepts request
m_we  out  1  request write enable
m_addr  out  ADDR_W  request address
m_wdata  out  DATA_W  request write data
m_wstrb  out  DATA_W/8  request byte enables (0 for reads)
m_rvalid  in  1  response/write-ack, one per accepted request
m_rdata  in  DATA_W  read response data

Behaviour:
- Reset, synchronous: state=IDLE, start=1, both done flags 0, IF_inst=0, mem_rdata=0, m_valid=0, m_we=0, m_addr/m_wdata/m_wstrb=0. A reset mid-transaction abandons it; a later m_rvalid is ignored.
- States: IDLE, REQ_MEM, WAIT_MEM, REQ_IF, WAIT_IF.
- Stage start: first IDLE cycle with start=1 (after reset or after a step).
  - if_req and mem_req are sampled only at stage start.
  - A side with req=0 gets its done flag set at that edge.
  - Inputs are held stable by the pipeline until the step.
- IDLE at stage start:
  - mem_req=1 -> REQ_MEM.
  - else if_req=1 -> REQ_IF.
  - else stay in IDLE; both flags set next cycle.
  - start clears at this edge.
- REQ_x:
  - m_valid=1; fields come combinationally from the selected requester. For IF: m_we=0, m_wstrb=0.
  - Stay until m_ready=1, then -> WAIT_x.
- WAIT_x:
  - m_valid=0. m_rvalid is ignored in every other state.
  - On m_rvalid, the matching rdata register captures m_rdata (stores capture nothing; mem_rdata is held) and the flag is set at the edge.
  - WAIT_MEM exit: if IF is still pending -> REQ_IF directly, else -> IDLE.
  - WAIT_IF exit: -> IDLE.
- IF_DONE/MEM_DONE are registered flags. They stay 1 until the step cycle and clear at the following edge. start=1 at that edge.
- Step cycle: no new request is issued. Stage start is the next cycle.
- No back-to-back stages without an intervening IDLE cycle.
- Latency with zero-wait memory (m_ready=1, m_rvalid 1 cycle after acceptance):
  - IF-only stage: IF_DONE at cycle 3 after stage start (IDLE, REQ_IF, WAIT_IF, flag).
  - MEM+IF stage: both done at cycle 5.
- Back-pressure: m_valid and all m_* fields are held constant while m_ready=0.
- Only one outstanding request; the arbiter never asserts m_valid while in WAIT_x.
- Target RTL size is about 150-250 lines.

Test Plan:
- Reset: assert rst 2 cycles during REQ_IF with m_ready=0 -> m_valid=0, IF_DONE=0, MEM_DONE=0 next cycle. An m_rvalid 3 cycles later is ignored and leaves IF_inst=0.
- IF-only: if_req=1, if_addr=0x100, mem_req=0, zero-wait memory returning 0x00500093 -> MEM_DONE=1 one cycle after stage start. m_addr=0x100, m_we=0 while REQ_IF. IF_DONE=1 with IF_inst=0x00500093 three cycles after stage start; both flags clear the cycle after the step.
- Load and fetch: mem_req=1, mem_we=0, mem_addr=0x2000, if_addr=0x104 -> first request is 0x2000, second is 0x104. mem_rdata=0xDEADBEEF is held while IF is served; both done at cycle 5.
- Store with back-pressure: mem_we=1, mem_wdata=0x11223344, mem_wstrb=0xF, m_ready low 4 cycles -> m_valid and all fields stable for 5 cycles. m_wstrb=0xF, m_we=1. mem_rdata is unchanged after the ack.
- Spurious response: m_rvalid pulsed while in IDLE and REQ_MEM -> no flag change, no data capture.
- No-request stage: if_req=0, mem_req=0 -> both done one cycle after stage start. m_valid never asserts. Step, then a new stage start follows.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared between instruction fetch and data access
// MEM is served before IF in a stage; sticky done flags clear the edge after both are set.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                IF_DONE,
  output logic [DATA_W-1:0]   IF_inst,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                MEM_DONE,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_MEM,
    S_WAIT_MEM,
    S_REQ_IF,
    S_WAIT_IF
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_start;
  logic                r_if_done;
  logic                r_mem_done;
  logic [DATA_W-1:0]   r_if_inst;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                w_step;
  logic                w_stage_start;

  assign w_step        = r_if_done & r_mem_done;
  assign w_stage_start = (r_state == S_IDLE) & r_start;

  assign IF_DONE   = r_if_done;
  assign MEM_DONE  = r_mem_done;
  assign IF_inst   = r_if_inst;
  assign mem_rdata = r_mem_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_stage_start) begin
          if (mem_req)     w_next = S_REQ_MEM;
          else if (if_req) w_next = S_REQ_IF;
        end
      end
      S_REQ_MEM:  if (m_ready) w_next = S_WAIT_MEM;
      // A fetch still pending goes straight out without an IDLE bubble
      S_WAIT_MEM: if (m_rvalid) w_next = r_if_done ? S_IDLE : S_REQ_IF;
      S_REQ_IF:   if (m_ready) w_next = S_WAIT_IF;
      S_WAIT_IF:  if (m_rvalid) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    case (r_state)
      S_REQ_MEM: begin
        m_valid = 1'b1;
        m_we    = mem_we;
        m_addr  = mem_addr;
        m_wdata = mem_wdata;
        m_wstrb = mem_we ? mem_wstrb : '0;
      end
      S_REQ_IF: begin
        m_valid = 1'b1;
        m_addr  = if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b1;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_step) begin
        r_if_done  <= 1'b0;
        r_mem_done <= 1'b0;
        r_start    <= 1'b1;
      end else begin
        if (w_stage_start) begin
          r_start <= 1'b0;
          if (!mem_req) r_mem_done <= 1'b1;
          if (!if_req)  r_if_done  <= 1'b1;
        end
        if ((r_state == S_WAIT_MEM) && m_rvalid) begin
          r_mem_done <= 1'b1;
          if (!mem_we) r_mem_rdata <= m_rdata;
        end
        if ((r_state == S_WAIT_IF) && m_rvalid) begin
          r_if_done <= 1'b1;
          r_if_inst <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Each stage is predicted as a request/accept/response timeline computed from chosen memory delays.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        IF_DONE;
  logic [31:0] IF_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        MEM_DONE;
  logic [31:0] mem_rdata;
  logic        m_valid;
  logic        m_ready;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_if_inst;
  logic [31:0] exp_mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .IF_DONE   (IF_DONE),
    .IF_inst   (IF_inst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .MEM_DONE  (MEM_DONE),
    .mem_rdata (mem_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    exp_if_inst   = '0;
    exp_mem_rdata = '0;
  endtask

  // One pipeline stage from its stage-start cycle (c=0) through the step cycle.
  // A transaction issued at cycle r with ready delay dr and response delay dv is
  // accepted at r+dr, answered at r+dr+dv and its flag shows one cycle later.
  task automatic run_stage(input string nm, input bit mreq, input bit mwe,
                           input logic [31:0] maddr, input logic [31:0] mwdata,
                           input logic [3:0] mwstrb, input bit ireq,
                           input logic [31:0] iaddr, input logic [31:0] rd_mem,
                           input logic [31:0] rd_if, input int dr_mem, input int dv_mem,
                           input int dr_if, input int dv_if, input bit spur);
    int rs_m, ac_m, rv_m, dn_m, rs_i, ac_i, rv_i, dn_i, t, last;
    bit exp_v, in_m, in_i, in_wait;
    logic [31:0] ea, ewd;
    logic [3:0] ews;
    bit ewe;
    mem_req   = mreq;
    mem_we    = mwe;
    mem_addr  = maddr;
    mem_wdata = mwdata;
    mem_wstrb = mwstrb;
    if_req    = ireq;
    if_addr   = iaddr;
    t = 0;
    rs_m = -10; ac_m = -10; rv_m = -10; dn_m = 1;
    rs_i = -10; ac_i = -10; rv_i = -10; dn_i = 1;
    if (mreq) begin
      rs_m = t + 1; ac_m = rs_m + dr_mem; rv_m = ac_m + dv_mem; dn_m = rv_m + 1; t = rv_m;
    end
    if (ireq) begin
      rs_i = t + 1; ac_i = rs_i + dr_if; rv_i = ac_i + dv_if; dn_i = rv_i + 1;
    end
    last = (dn_m > dn_i) ? dn_m : dn_i;
    for (int c = 0; c <= last; c++) begin
      in_m    = (c >= rs_m) && (c <= ac_m);
      in_i    = (c >= rs_i) && (c <= ac_i);
      exp_v   = in_m || in_i;
      in_wait = ((c > ac_m) && (c < rv_m)) || ((c > ac_i) && (c < rv_i));
      if (mreq && !mwe && (c == dn_m)) exp_mem_rdata = rd_mem;
      if (ireq && (c == dn_i)) exp_if_inst = rd_if;
      n_vec++;
      if (m_valid !== exp_v) begin
        n_err++;
        $display("FAIL %s m_valid c=%0d got %b exp %b", nm, c, m_valid, exp_v);
      end
      if (exp_v) begin
        ea  = in_m ? maddr : iaddr;
        ewe = in_m ? mwe : 1'b0;
        ews = (in_m && mwe) ? mwstrb : 4'h0;
        ewd = mwdata;
        n_vec++;
        if (m_addr !== ea || m_we !== ewe || m_wstrb !== ews) begin
          n_err++;
          $display("FAIL %s m_fields c=%0d got addr=%h we=%b strb=%h exp addr=%h we=%b strb=%h",
                   nm, c, m_addr, m_we, m_wstrb, ea, ewe, ews);
        end
        if (in_m && mwe) begin
          n_vec++;
          if (m_wdata !== ewd) begin
            n_err++;
            $display("FAIL %s m_wdata c=%0d got %h exp %h", nm, c, m_wdata, ewd);
          end
        end
      end
      n_vec++;
      if (IF_DONE !== (c >= dn_i) || MEM_DONE !== (c >= dn_m)) begin
        n_err++;
        $display("FAIL %s done_flags c=%0d got if=%b mem=%b exp if=%b mem=%b",
                 nm, c, IF_DONE, MEM_DONE, c >= dn_i, c >= dn_m);
      end
      n_vec++;
      if (IF_inst !== exp_if_inst || mem_rdata !== exp_mem_rdata) begin
        n_err++;
        $display("FAIL %s rdata c=%0d got inst=%h mrd=%h exp inst=%h mrd=%h",
                 nm, c, IF_inst, mem_rdata, exp_if_inst, exp_mem_rdata);
      end
      if ((c == ac_m) || (c == ac_i))                        m_ready = 1'b1;
      else if (((c >= rs_m) && (c < ac_m)) || ((c >= rs_i) && (c < ac_i))) m_ready = 1'b0;
      else                                                   m_ready = 1'($urandom % 2);
      if ((c == rv_m) || (c == rv_i)) m_rvalid = 1'b1;
      else if (in_wait)               m_rvalid = 1'b0;
      else                            m_rvalid = spur ? 1'b1 : 1'(($urandom % 4) == 0);
      m_rdata = (c == rv_m) ? rd_mem : (c == rv_i) ? rd_if : $urandom;
      tick();
    end
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    do_reset();
    n_vec++;
    if (m_valid !== 1'b0 || IF_DONE !== 1'b0 || MEM_DONE !== 1'b0 ||
        IF_inst !== 32'h0 || mem_rdata !== 32'h0 || m_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state got valid=%b if=%b mem=%b inst=%h mrd=%h addr=%h exp all zero",
               m_valid, IF_DONE, MEM_DONE, IF_inst, mem_rdata, m_addr);
    end
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    n_vec++;
    if (m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_req_if got m_valid=%b exp 1", m_valid);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (m_valid !== 1'b0 || IF_DONE !== 1'b0 || MEM_DONE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abandon got valid=%b if=%b mem=%b exp 0 0 0", m_valid, IF_DONE, MEM_DONE);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    m_rvalid = 1'b1;
    m_rdata  = 32'hBADBAD00;
    tick();
    m_rvalid = 1'b0;
    n_vec++;
    if (IF_inst !== 32'h0 || IF_DONE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_late_rvalid got inst=%h if_done=%b exp 0 0", IF_inst, IF_DONE);
    end
    if_req = 1'b0;
    do_reset();
  endtask

  task automatic test_if_only();
    run_stage("if_only", 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h100, 32'h0, 32'h00500093,
              0, 1, 0, 1, 0);
  endtask

  task automatic test_load_fetch();
    run_stage("load_fetch", 1, 0, 32'h2000, 32'h0, 4'h0, 1, 32'h104, 32'hDEADBEEF,
              32'h00A00113, 0, 1, 0, 1, 0);
  endtask

  task automatic test_store_backpressure();
    run_stage("store_bp", 1, 1, 32'h3000, 32'h11223344, 4'hF, 1, 32'h108, 32'h55555555,
              32'h00208233, 4, 1, 1, 2, 0);
  endtask

  task automatic test_spurious();
    run_stage("spurious", 1, 0, 32'h2004, 32'h0, 4'h0, 1, 32'h10C, 32'hCAFEF00D,
              32'h00000013, 2, 2, 1, 1, 1);
  endtask

  task automatic test_no_request();
    run_stage("no_req", 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 1, 1);
    run_stage("after_no_req", 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h110, 32'h0, 32'h12345678,
              0, 1, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_stage("random", 1'($urandom % 2), 1'($urandom % 2), $urandom, $urandom,
                4'($urandom), 1'($urandom % 2), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    exp_if_inst = '0; exp_mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_if_only();
    test_load_fetch();
    test_store_backpressure();
    test_spurious();
    test_no_request();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
